// File: rtl/bcsa_err_recovery.sv
// rtl/bcsa_err_recovery.sv - variable-latency exact repair for the block carry-speculative adder
//
// Purpose: accepts an operand pair and forms the speculative block-carry sum.
// Each mispredicted block carry-in is flagged in err_mask. When any block is
// flagged, the exact sum is rebuilt by rippling the true carry one block per
// cycle. Results are returned over a valid/ready handshake.
//
// Ports:
//   clk, rst_n                  clock (rising edge); asynchronous active-low reset
//   in_valid/in_ready           operand handshake (a_in, b_in, cin)
//   out_valid/out_ready         result handshake
//   sum_exact/cout_exact        exact a+b+cin
//   sum_approx/cout_approx      speculative sum and carry-out
//   err_mask                    bit k set = block k carry-in mispredicted (bit 0 always 0)
//   lat_cycles                  cycles from accept to out_valid
//   stat_ops/stat_errs          saturating op / errored-op counters
//
// Optional: define BCSA_STATS_EN to build the stat_ops/stat_errs counters;
// without it both outputs are tied to 0.

module bcsa_err_recovery #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       a_in,
  input  logic [WIDTH-1:0]       b_in,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       sum_exact,
  output logic                   cout_exact,
  output logic [WIDTH-1:0]       sum_approx,
  output logic                   cout_approx,
  output logic [WIDTH/BLK-1:0]   err_mask,
  output logic [3:0]             lat_cycles,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_errs
);

  localparam int NBLK = WIDTH / BLK;
  localparam int IDXW = $clog2(NBLK + 1);

  typedef enum logic [1:0] {IDLE, SPEC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic               cin_q;
  logic [WIDTH-1:0]   sum_exact_q, sum_approx_q;
  logic               cout_exact_q, cout_approx_q;
  logic [NBLK-1:0]    err_q;
  logic [3:0]         lat_q;
  logic               out_valid_q;
  logic               carry_q;
  logic [IDXW-1:0]    idx_q;

  // Carry-out of a BLK-bit add without a wide temporary:
  // x+y overflows iff x > ~y; x+y+1 overflows iff x >= ~y.
  function automatic logic blk_carry(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                     input logic c);
    return c ? (x >= ~y) : (x > ~y);
  endfunction

  function automatic logic [BLK-1:0] blk_sum(input logic [BLK-1:0] x, input logic [BLK-1:0] y,
                                             input logic c);
    return x + y + {{(BLK-1){1'b0}}, c};
  endfunction

  // Speculative evaluation of the registered operands.
  logic [NBLK-1:0]  spec_c, true_c, err_c;
  logic [WIDTH-1:0] approx_c;
  logic             cout_approx_c;

  always_comb begin
    spec_c        = '0;
    true_c        = '0;
    err_c         = '0;
    approx_c      = '0;
    spec_c[0]     = cin_q;
    true_c[0]     = cin_q;
    for (int k = 1; k < NBLK; k++) begin
      spec_c[k] = blk_carry(a_q[(k-1)*BLK +: BLK], b_q[(k-1)*BLK +: BLK], 1'b0);
      true_c[k] = blk_carry(a_q[(k-1)*BLK +: BLK], b_q[(k-1)*BLK +: BLK], true_c[k-1]);
      err_c[k]  = spec_c[k] ^ true_c[k];
    end
    for (int k = 0; k < NBLK; k++) begin
      approx_c[k*BLK +: BLK] = blk_sum(a_q[k*BLK +: BLK], b_q[k*BLK +: BLK], spec_c[k]);
    end
    cout_approx_c = blk_carry(a_q[WIDTH-1 -: BLK], b_q[WIDTH-1 -: BLK], spec_c[NBLK-1]);
  end

  // Block currently being repaired in FIX.
  logic [BLK-1:0] fix_a, fix_b;
  assign fix_a = a_q[idx_q*BLK +: BLK];
  assign fix_b = b_q[idx_q*BLK +: BLK];

  logic handshake;
  assign handshake = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_valid) state_d = SPEC;
      SPEC: state_d = (err_c == '0) ? DONE : FIX;
      FIX:  if (idx_q == IDXW'(NBLK - 1)) state_d = DONE;
      DONE: if (handshake) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      a_q           <= '0;
      b_q           <= '0;
      cin_q         <= 1'b0;
      sum_exact_q   <= '0;
      sum_approx_q  <= '0;
      cout_exact_q  <= 1'b0;
      cout_approx_q <= 1'b0;
      err_q         <= '0;
      lat_q         <= '0;
      out_valid_q   <= 1'b0;
      carry_q       <= 1'b0;
      idx_q         <= '0;
    end else begin
      state_q     <= state_d;
      // out_valid is registered one cycle after DONE is entered, which
      // gives the 2 / NBLK+1 accept-to-valid latency.
      out_valid_q <= (state_q == DONE) && !handshake;
      if (state_q != IDLE && !out_valid_q) lat_q <= lat_q + 4'd1;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a_in;
            b_q   <= b_in;
            cin_q <= cin;
            lat_q <= '0;
          end
        end
        SPEC: begin
          sum_approx_q  <= approx_c;
          cout_approx_q <= cout_approx_c;
          err_q         <= err_c;
          idx_q         <= IDXW'(1);
          carry_q       <= true_c[1];
          if (err_c == '0) begin
            sum_exact_q  <= approx_c;
            cout_exact_q <= cout_approx_c;
          end else begin
            sum_exact_q[BLK-1:0] <= blk_sum(a_q[BLK-1:0], b_q[BLK-1:0], cin_q);
          end
        end
        FIX: begin
          sum_exact_q[idx_q*BLK +: BLK] <= blk_sum(fix_a, fix_b, carry_q);
          carry_q <= blk_carry(fix_a, fix_b, carry_q);
          idx_q   <= idx_q + IDXW'(1);
          if (idx_q == IDXW'(NBLK - 1)) cout_exact_q <= blk_carry(fix_a, fix_b, carry_q);
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = out_valid_q;
  assign sum_exact   = sum_exact_q;
  assign cout_exact  = cout_exact_q;
  assign sum_approx  = sum_approx_q;
  assign cout_approx = cout_approx_q;
  assign err_mask    = err_q;
  assign lat_cycles  = lat_q;

`ifdef BCSA_STATS_EN
  logic [15:0] ops_q, errs_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ops_q  <= '0;
      errs_q <= '0;
    end else if (handshake) begin
      if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
      if (err_q != '0 && errs_q != 16'hFFFF) errs_q <= errs_q + 16'd1;
    end
  end
  assign stat_ops  = ops_q;
  assign stat_errs = errs_q;
`else
  assign stat_ops  = 16'd0;
  assign stat_errs = 16'd0;
`endif

endmodule

// File: tb/tb_bcsa_err_recovery.sv
// tb/tb_bcsa_err_recovery.sv - self-checking bench for bcsa_err_recovery

module tb_bcsa_err_recovery;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic        cin = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum_exact, sum_approx;
  logic        cout_exact, cout_approx;
  logic [3:0]  err_mask;
  logic [3:0]  lat_cycles;
  logic [15:0] stat_ops, stat_errs;

  bcsa_err_recovery dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum_exact(sum_exact), .cout_exact(cout_exact), .sum_approx(sum_approx),
    .cout_approx(cout_approx), .err_mask(err_mask), .lat_cycles(lat_cycles),
    .stat_ops(stat_ops), .stat_errs(stat_errs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] se;
    logic        ce;
    logic [15:0] sa;
    logic        ca;
    logic [3:0]  em;
    logic [3:0]  lat;
  } res_t;

  res_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic res_t sample();
    return {sum_exact, cout_exact, sum_approx, cout_approx, err_mask, lat_cycles};
  endfunction

  // Reference: exact sum from a full-width add; true carry into block k from
  // the low k*4 bits; speculated carry from block k-1 alone.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    res_t r;
    int unsigned full, tc, sc, blk, m;
    full = a + b + c;
    r = '0;
    r.se = full[15:0];
    r.ce = full[16];
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        tc = c;
        sc = c;
      end else begin
        m  = (32'd1 << (4 * k)) - 1;
        tc = (((a & m) + (b & m) + c) >> (4 * k)) & 1;
        sc = ((((a >> (4 * (k - 1))) & 15) + ((b >> (4 * (k - 1))) & 15)) >> 4) & 1;
      end
      blk = ((a >> (4 * k)) & 15) + ((b >> (4 * k)) & 15) + sc;
      r.sa[4*k +: 4] = blk[3:0];
      if (k == 3) r.ca = blk[4];
      if (sc != tc) r.em[k] = 1'b1;
    end
    r.lat = (r.em != 0) ? 4'd5 : 4'd2;
    return r;
  endfunction

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c, input res_t e);
    @(negedge clk);
    a_in = a; b_in = b; cin = c; in_valid = 1'b1;
    exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(output res_t r, output int cyc);
    cyc = 0;
    while (cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) break;
    end
    r = sample();
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    n_cmp++;
    if (sample() !== res_t'(0) || stat_ops !== 16'd0 || stat_errs !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_outs: got %h ops=%h errs=%h want all 0", sample(), stat_ops, stat_errs);
    end
  endtask

  task automatic test_plan();
    logic [15:0] ta[3], tb[3];
    logic        tc[3];
    res_t        te[3];
    res_t        obs, e;
    int          cyc;
    ta[0] = 16'h0001; tb[0] = 16'h0002; tc[0] = 1'b0;
    te[0] = '{se:16'h0003, ce:1'b0, sa:16'h0003, ca:1'b0, em:4'b0000, lat:4'd2};
    ta[1] = 16'h00FF; tb[1] = 16'h0001; tc[1] = 1'b0;
    te[1] = '{se:16'h0100, ce:1'b0, sa:16'h0000, ca:1'b0, em:4'b0100, lat:4'd5};
    ta[2] = 16'hFFFF; tb[2] = 16'h0000; tc[2] = 1'b1;
    te[2] = '{se:16'h0000, ce:1'b1, sa:16'hFFF0, ca:1'b0, em:4'b1110, lat:4'd5};
    for (int i = 0; i < 3; i++) begin
      send(ta[i], tb[i], tc[i], te[i]);
      wait_out(obs, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || obs !== e) begin
        n_bad++;
        $display("FAIL plan%0d_result: valid=%b got %h want %h", i, out_valid, obs, e);
      end
      n_cmp++;
      if (cyc != int'(e.lat)) begin
        n_bad++;
        $display("FAIL plan%0d_latency: got %0d cycles want %0d", i, cyc, e.lat);
      end
      release_out();
      n_cmp++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL plan%0d_release: out_valid=%b in_ready=%b want 0 1", i, out_valid, in_ready);
      end
    end
    n_cmp++;
`ifdef BCSA_STATS_EN
    if (stat_ops !== 16'd3 || stat_errs !== 16'd2) begin
      n_bad++;
      $display("FAIL plan_stats: ops=%0d errs=%0d want 3 2", stat_ops, stat_errs);
    end
`else
    if (stat_ops !== 16'd0 || stat_errs !== 16'd0) begin
      n_bad++;
      $display("FAIL plan_stats: ops=%0d errs=%0d want 0 0", stat_ops, stat_errs);
    end
`endif
  endtask

  task automatic test_back_to_back();
    res_t        obs, e;
    int          cyc;
    logic [15:0] a, b;
    logic        c;
    for (int i = 0; i < 24; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 4 == 0) b = ~a;
      c = 1'($urandom);
      send(a, b, c, model(a, b, c));
      wait_out(obs, cyc);
      e = exp_q.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || obs !== e || cyc != int'(e.lat)) begin
        n_bad++;
        $display("FAIL b2b%0d: a=%h b=%h c=%b valid=%b got %h/%0d want %h/%0d",
                 i, a, b, c, out_valid, obs, cyc, e, e.lat);
      end
      release_out();
    end
  endtask

  task automatic test_stall();
    res_t obs, e, hold;
    int   cyc;
    int   bad;
    send(16'h00FF, 16'h0001, 1'b0, model(16'h00FF, 16'h0001, 1'b0));
    wait_out(obs, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e) begin
      n_bad++;
      $display("FAIL stall_result: valid=%b got %h want %h", out_valid, obs, e);
    end
    hold = e;
    @(negedge clk);
    a_in = 16'hAAAA; b_in = 16'h5555; cin = 1'b1; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (sample() !== hold || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL stall_hold: %0d unstable cycles, last %h valid=%b in_ready=%b want %h 1 0",
               bad, sample(), out_valid, in_ready, hold);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum_exact !== hold.se) begin
      n_bad++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b sum=%h want 1 0 %h",
               in_ready, out_valid, sum_exact, hold.se);
    end
  endtask

  task automatic test_reset_mid();
    res_t obs, e, e_lit;
    int   cyc, seen;
    @(negedge clk);
    a_in = 16'h00FF; b_in = 16'h0001; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sample() !== res_t'(0) || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_clear: got %h valid=%b want 0 0", sample(), out_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_abort: out_valid seen %0d times, in_ready=%b want 0 1", seen, in_ready);
    end
    e_lit = '{se:16'h2345, ce:1'b0, sa:16'h2345, ca:1'b0, em:4'b0000, lat:4'd2};
    send(16'h1234, 16'h1111, 1'b0, e_lit);
    wait_out(obs, cyc);
    e = exp_q.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || obs !== e || cyc != 2) begin
      n_bad++;
      $display("FAIL midreset_next: valid=%b got %h/%0d want %h/2", out_valid, obs, cyc, e);
    end
    release_out();
    n_cmp++;
`ifdef BCSA_STATS_EN
    if (stat_ops !== 16'd1 || stat_errs !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_stats: ops=%0d errs=%0d want 1 0", stat_ops, stat_errs);
    end
`else
    if (stat_ops !== 16'd0 || stat_errs !== 16'd0) begin
      n_bad++;
      $display("FAIL midreset_stats: ops=%0d errs=%0d want 0 0", stat_ops, stat_errs);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_plan();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
